// File: rtl/logic_reduce_pipe_pkg.sv
// Shared definitions for logic_reduce_pipe: mode encodings, the reset-time
// CONFIG-to-mode mapping and the per-bit two-operand combine.
package logic_reduce_pipe_pkg;

    localparam logic [1:0] MODE_OR   = 2'd0;
    localparam logic [1:0] MODE_AND  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_XNOR = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Unknown CONFIG values fall back to AND.
    function automatic logic [1:0] cfg_to_mode(input int cfg);
        case (cfg)
            0:       return MODE_OR;
            1:       return MODE_AND;
            2:       return MODE_XOR;
            3:       return MODE_XNOR;
            default: return MODE_AND;
        endcase
    endfunction

    function automatic logic combine(input logic a, input logic b, input logic [1:0] mode);
        case (mode)
            MODE_OR:  return a | b;
            MODE_AND: return a & b;
            MODE_XOR: return a ^ b;
            default:  return ~(a ^ b);
        endcase
    endfunction

endpackage

// File: rtl/logic_reduce_pipe.sv
// Streaming bitwise reducer: each beat reduces NUM_IN operands, multi-beat
// transactions are folded into an accumulator, one registered result per transaction.
module logic_reduce_pipe
    import logic_reduce_pipe_pkg::*;
#(
    parameter int CONFIG = 0,
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_load,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    busy,
    output logic [1:0]              mode
);

    function automatic logic [WIDTH-1:0] combine_vec(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = combine(a[i], b[i], m);
        end
        return r;
    endfunction

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic [1:0]       mode_reg, mode_next;

    logic [1:0]       base_mode;
    logic [WIDTH-1:0] beat;
    logic [WIDTH-1:0] acc_comb;
    logic             accept;

    // XNOR reduction is the inverted XOR chain, not a chain of XNORs.
    assign base_mode = (mode_reg == MODE_XNOR) ? MODE_XOR : mode_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_red
            logic [WIDTH-1:0] stage;
            if (gi == 0) begin : g_head
                assign stage = in_data[0 +: WIDTH];
            end else begin : g_tail
                assign stage = combine_vec(g_red[gi-1].stage, in_data[gi*WIDTH +: WIDTH], base_mode);
            end
        end
    endgenerate

    assign beat     = (mode_reg == MODE_XNOR) ? ~g_red[NUM_IN-1].stage : g_red[NUM_IN-1].stage;
    assign acc_comb = combine_vec(acc_reg, beat, mode_reg);

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        mode_next      = mode_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_last) begin
                        out_data_next  = beat;
                        out_valid_next = 1'b1;
                    end else begin
                        acc_next   = beat;
                        state_next = ST_ACCUM;
                    end
                end
                default: begin
                    if (in_last) begin
                        out_data_next  = acc_comb;
                        out_valid_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        acc_next = acc_comb;
                    end
                end
            endcase
        end

        // Mode may only change between transactions, never alongside a beat.
        if (cfg_load && (state_reg == ST_IDLE) && !accept) begin
            mode_next = cfg_mode;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            mode_reg      <= cfg_to_mode(CONFIG);
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            mode_reg      <= mode_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg == ST_ACCUM);
    assign mode      = mode_reg;

endmodule

// File: doc/logic_reduce_pipe.md
LOGIC_REDUCE_PIPE -- requirements
Module: logic_reduce_pipe

Interface
REQ-001 SHALL have parameter CONFIG, default 0, reset-time operation mode (0 OR, 1 AND, 2 XOR, 3 XNOR; any other value maps to AND).
REQ-002 SHALL have parameter WIDTH, default 4, bit width of each operand and of the result.
REQ-003 SHALL have parameter NUM_IN, default 2, operands per beat (legal range 2..16).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port cfg_mode, input, 2, requested operation mode.
REQ-007 SHALL have port cfg_load, input, 1, request to latch cfg_mode.
REQ-008 SHALL have port in_valid, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both 1.
REQ-010 SHALL have port in_last, input, 1, final beat of a transaction.
REQ-011 SHALL have port in_data, input, NUM_IN*WIDTH, operand k in bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both 1.
REQ-014 SHALL have port out_data, output, WIDTH, transaction result.
REQ-015 SHALL have port busy, output, 1, high while a multi-beat transaction is open (state ACCUM).
REQ-016 SHALL have port mode, output, 2, currently latched mode.

Function
REQ-017 Beat result SHALL be the bitwise reduction of all NUM_IN operands under the latched mode; XNOR is the inversion of the XOR reduction.
REQ-018 States SHALL be IDLE and ACCUM; the accumulator SHALL be combined with each beat result using the same mode.
REQ-019 In IDLE, an accepted beat with in_last=1 SHALL load the beat result into the output register; with in_last=0 it SHALL load the accumulator and enter ACCUM.
REQ-020 In ACCUM, an accepted non-last beat SHALL update accumulator = acc OP beat; an accepted last beat SHALL load (acc OP beat) into the output register and return to IDLE.
REQ-021 Latency SHALL be one cycle: last beat accepted at edge N gives out_valid=1 after edge N.
REQ-022 in_ready SHALL equal (!out_valid || out_ready) and SHALL NOT depend combinationally on in_valid.
REQ-023 out_valid and out_data SHALL hold stable until consumed; consume plus a new last beat in the same cycle SHALL keep out_valid=1 with new data.
REQ-024 cfg_load SHALL update mode only when state is IDLE and no beat is accepted in that cycle; otherwise it SHALL be ignored.
REQ-025 A mode change SHALL take effect on the next accepted beat, never mid-transaction.

Reset
REQ-026 On reset: state IDLE, out_valid=0, out_data=0, accumulator=0, busy=0, mode=CONFIG mapping (REQ-001).
REQ-027 Reset mid-transaction SHALL discard the accumulator and any pending output, with no output produced.
REQ-028 in_ready SHALL be 1 in the cycle after reset deassertion.

Structure
REQ-029 A shared package SHALL hold the mode constants (MODE_OR, MODE_AND, MODE_XOR, MODE_XNOR), the CONFIG-to-mode mapping function and the two-operand combine function.
REQ-030 No sub-module is required; the NUM_IN reduction SHALL be a generate loop inside logic_reduce_pipe.

Verification (WIDTH=4, NUM_IN=2, operands given as in0,in1)
REQ-031 CONFIG=0, single beat 1010,0101, last -> out_data 1111, out_valid next cycle.
REQ-032 cfg_load mode=2, then 3-beat burst (0001,0010) (0100,0001) (1111,0000 last) -> busy high during burst, out_data 1001.
REQ-033 out_ready=0 with two single-beat transactions -> first result held, in_ready=0, second beat held off; raising out_ready delivers both in order.
REQ-034 cfg_load mode=1 asserted while busy=1 -> ignored, burst completes in the old mode, mode output unchanged.
REQ-035 reset asserted mid-burst -> out_valid=0, busy=0, mode=CONFIG; the next single beat produces a result independent of the discarded beats.
REQ-036 CONFIG=7, single beat 1100,1010 -> mode=1, out_data 1000.
